// File: rtl/fifo_pkg.sv
// Shared FIFO types and sizing helpers, common to the single- and dual-clock FIFOs.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width for a DEPTH-entry array; at least one bit.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Width that can hold an occupancy count of 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array: one write port, one address-indexed read port.
// Registered read in standard mode, combinational read in first-word-fall-through mode.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = ptr_width(DEPTH),
  parameter fifo_mode_e  MODE   = FIFO_STD
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Array write; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wdata_i;
    end
  end

  if (MODE == FIFO_STD) begin : g_reg_rd
    logic [WIDTH-1:0] rdata_q;

    // Output register loads only on a pop and otherwise holds the last word read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        rdata_q <= '0;
      end else if (rd_en_i) begin
        rdata_q <= mem_q[rd_addr_i];
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_comb_rd
    logic unused_rd;
    assign unused_rd = rd_en_i ^ rst_n_i;
    assign rdata_o   = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with selectable read mode, fill level,
// run-time almost-full/almost-empty thresholds, synchronous flush and error pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned FWFT  = 0,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             wr_error_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             almost_empty_o,
  output logic             rd_error_o,
  input  logic [CNT_W-1:0] af_level_i,
  input  logic [CNT_W-1:0] ae_level_i,
  output logic [CNT_W-1:0] level_o
);

  localparam int unsigned      PTR_W   = ptr_width(DEPTH);
  localparam fifo_mode_e       MODE    = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_error_q, wr_error_d;
  logic             rd_error_q, rd_error_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PtrLast) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Flags decode the registered count only.
  assign full_o         = (count_q == CntFull);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= af_level_i);
  assign almost_empty_o = (count_q <= ae_level_i);
  assign level_o        = count_q;
  assign wr_error_o     = wr_error_q;
  assign rd_error_o     = rd_error_q;

  // Flush suppresses both transfers; reads never bypass a same-cycle write.
  assign wr_acc = wr_en_i & ~full_o & ~flush_i;
  assign rd_acc = rd_en_i & ~empty_o & ~flush_i;

  // Next-state for pointers, occupancy and error pulses; flush overrides everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_error_d = 1'b0;
    rd_error_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_error_d = wr_en_i & full_o;
      rd_error_d = rd_en_i & empty_o;
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_error_q <= wr_error_d;
      rd_error_q <= rd_error_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .MODE   (MODE)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wdata_i   (wdata_i),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rdata_o   (mem_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    logic [WIDTH-1:0] hold_q;

    // Remember the word on show so the output holds once the FIFO drains or flushes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        hold_q <= '0;
      end else if (!empty_o) begin
        hold_q <= mem_rdata;
      end
    end

    assign rdata_o = empty_o ? hold_q : mem_rdata;
  end else begin : g_std
    assign rdata_o = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (STD depth 8, STD depth 6, FWFT depth 8)
// checked every cycle against a sequence-number FIFO model, plus directed literal checks.
module tb_sync_fifo_param;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;

  logic [N-1:0] flush, wr, rd;
  logic [7:0]   wdata [N];
  logic [3:0]   af [N];
  logic [3:0]   ae [N];
  logic [N-1:0] full, afull, empty, aempty, werr, rerr;
  logic [7:0]   rdata [N];
  logic [3:0]   lvl0, lvl2;
  logic [2:0]   lvl1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush[0]), .wr_en_i(wr[0]), .wdata_i(wdata[0]),
    .full_o(full[0]), .almost_full_o(afull[0]), .wr_error_o(werr[0]), .rd_en_i(rd[0]),
    .rdata_o(rdata[0]), .empty_o(empty[0]), .almost_empty_o(aempty[0]), .rd_error_o(rerr[0]),
    .af_level_i(af[0]), .ae_level_i(ae[0]), .level_o(lvl0)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(6), .FWFT(0)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush[1]), .wr_en_i(wr[1]), .wdata_i(wdata[1]),
    .full_o(full[1]), .almost_full_o(afull[1]), .wr_error_o(werr[1]), .rd_en_i(rd[1]),
    .rdata_o(rdata[1]), .empty_o(empty[1]), .almost_empty_o(aempty[1]), .rd_error_o(rerr[1]),
    .af_level_i(af[1][2:0]), .ae_level_i(ae[1][2:0]), .level_o(lvl1)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush[2]), .wr_en_i(wr[2]), .wdata_i(wdata[2]),
    .full_o(full[2]), .almost_full_o(afull[2]), .wr_error_o(werr[2]), .rd_en_i(rd[2]),
    .rdata_o(rdata[2]), .empty_o(empty[2]), .almost_empty_o(aempty[2]), .rd_error_o(rerr[2]),
    .af_level_i(af[2]), .ae_level_i(ae[2]), .level_o(lvl2)
  );

  function automatic int dep(input int k);
    return (k == 1) ? 6 : 8;
  endfunction

  function automatic bit is_fw(input int k);
    return k == 2;
  endfunction

  function automatic int act_lvl(input int k);
    if (k == 0) return int'(lvl0);
    if (k == 1) return int'(lvl1);
    return int'(lvl2);
  endfunction

  task automatic check(input string name, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d): got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model: accepted writes are numbered ws, pops rs; level = ws - rs, head = log[rs].
  logic [7:0] log_q [N][256];
  int         ws [N];
  int         rs [N];
  logic [7:0] m_rd [N];
  logic [7:0] fw_last [N];
  bit         m_werr [N];
  bit         m_rerr [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        ws[k] = 0; rs[k] = 0; m_rd[k] = 8'h00; fw_last[k] = 8'h00;
        m_werr[k] = 1'b0; m_rerr[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int lv;
        lv = ws[k] - rs[k];
        if (lv > 0) fw_last[k] = log_q[k][rs[k] % 256];
        if (flush[k]) begin
          rs[k] = ws[k];
          m_werr[k] = 1'b0;
          m_rerr[k] = 1'b0;
        end else begin
          m_werr[k] = wr[k] && (lv == dep(k));
          m_rerr[k] = rd[k] && (lv == 0);
          if (rd[k] && lv > 0) begin
            if (!is_fw(k)) m_rd[k] = log_q[k][rs[k] % 256];
            rs[k]++;
          end
          if (wr[k] && lv < dep(k)) begin
            log_q[k][ws[k] % 256] = wdata[k];
            ws[k]++;
          end
        end
      end
    end
  end

  function automatic int exp_rdata(input int k);
    if (!is_fw(k)) return int'(m_rd[k]);
    if (ws[k] - rs[k] > 0) return int'(log_q[k][rs[k] % 256]);
    return int'(fw_last[k]);
  endfunction

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        int lv;
        lv = ws[k] - rs[k];
        check("level", k, act_lvl(k), lv);
        check("empty", k, int'(empty[k]), int'(lv == 0));
        check("full", k, int'(full[k]), int'(lv == dep(k)));
        check("almost_full", k, int'(afull[k]), int'(lv >= int'(af[k])));
        check("almost_empty", k, int'(aempty[k]), int'(lv <= int'(ae[k])));
        check("wr_error", k, int'(werr[k]), int'(m_werr[k]));
        check("rd_error", k, int'(rerr[k]), int'(m_rerr[k]));
        check("rdata", k, int'(rdata[k]), exp_rdata(k));
      end
    end
  end

  // Apply one cycle of inputs to instance k; returns 2 time units after the consuming edge.
  task automatic step(input int k, input bit f, input bit w, input bit r, input logic [7:0] d);
    flush[k] = f; wr[k] = w; rd[k] = r; wdata[k] = d;
    @(posedge clk);
    #2;
    flush[k] = 1'b0; wr[k] = 1'b0; rd[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nr;
    flush = '0; wr = '0; rd = '0;
    for (int k = 0; k < N; k++) begin
      wdata[k] = 8'h00;
      af[k] = (k == 1) ? 4'd5 : 4'd6;
      ae[k] = 4'd1;
    end
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2 chk_en = 1'b1;

    // Reset state
    check("rst_empty", 0, int'(empty[0]), 1);
    check("rst_full", 0, int'(full[0]), 0);
    check("rst_level", 0, int'(lvl0), 0);
    check("rst_aempty", 0, int'(aempty[0]), 1);
    check("rst_afull", 0, int'(afull[0]), 0);
    check("rst_errors", 0, int'({werr[0], rerr[0]}), 0);
    check("rst_rdata", 0, int'(rdata[0]), 0);

    // STD: three writes then three reads, data one cycle after each read edge
    step(0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 0, 8'h33);
    check("std_level3", 0, int'(lvl0), 3);
    step(0, 0, 0, 1, 8'h00);
    check("std_rd0", 0, int'(rdata[0]), 8'h11);
    check("std_level2", 0, int'(lvl0), 2);
    step(0, 0, 0, 1, 8'h00);
    check("std_rd1", 0, int'(rdata[0]), 8'h22);
    step(0, 0, 0, 1, 8'h00);
    check("std_rd2", 0, int'(rdata[0]), 8'h33);
    check("std_level0", 0, int'(lvl0), 0);
    check("std_empty", 0, int'(empty[0]), 1);
    step(0, 0, 0, 0, 8'h00);
    check("std_rd_hold", 0, int'(rdata[0]), 8'h33);

    // Fill to full, then overflow attempt
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 8'(8'hA0 + i));
      check("fill_level", 0, int'(lvl0), i + 1);
      check("fill_afull", 0, int'(afull[0]), int'(i + 1 >= 6));
      check("fill_full", 0, int'(full[0]), int'(i == 7));
    end
    step(0, 0, 1, 0, 8'hFF);
    check("ovf_wr_error", 0, int'(werr[0]), 1);
    check("ovf_level", 0, int'(lvl0), 8);
    step(0, 0, 0, 0, 8'h00);
    check("ovf_pulse_end", 0, int'(werr[0]), 0);

    // Full with simultaneous write and read: read wins, write rejected
    step(0, 0, 1, 1, 8'hEE);
    check("fullrw_rdata", 0, int'(rdata[0]), 8'hA0);
    check("fullrw_wr_error", 0, int'(werr[0]), 1);
    check("fullrw_level", 0, int'(lvl0), 7);
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0, 1, 8'h00);
      check("drain_rdata", 0, int'(rdata[0]), 8'hA0 + i);
    end
    check("drain_empty", 0, int'(empty[0]), 1);

    // Empty with simultaneous write and read: write accepted, read rejected
    step(0, 0, 1, 1, 8'h77);
    check("emptyrw_rd_error", 0, int'(rerr[0]), 1);
    check("emptyrw_level", 0, int'(lvl0), 1);
    check("emptyrw_rdata_hold", 0, int'(rdata[0]), 8'hA7);
    step(0, 0, 0, 1, 8'h00);
    check("emptyrw_rdata", 0, int'(rdata[0]), 8'h77);
    step(0, 0, 0, 1, 8'h00);
    check("udf_pulse1", 0, int'(rerr[0]), 1);
    step(0, 0, 0, 1, 8'h00);
    check("udf_pulse2", 0, int'(rerr[0]), 1);
    step(0, 0, 0, 0, 8'h00);
    check("udf_pulse_end", 0, int'(rerr[0]), 0);

    // Wrap-around on depth 6: 20 words, level swinging 0..6
    nw = 0;
    nr = 0;
    while (nw < 20) begin
      while (nw < 20 && nw - nr < 6) begin
        step(1, 0, 1, 0, 8'(8'h40 + nw));
        nw++;
      end
      check("wrap_level", 1, int'(lvl1), nw - nr);
      while (nr < nw) begin
        step(1, 0, 0, 1, 8'h00);
        check("wrap_rdata", 1, int'(rdata[1]), 8'h40 + nr);
        nr++;
      end
      check("wrap_empty", 1, int'(empty[1]), 1);
    end

    // FWFT: first word visible without a read
    step(2, 0, 1, 0, 8'h5A);
    check("fwft_first", 2, int'(rdata[2]), 8'h5A);
    check("fwft_level1", 2, int'(lvl2), 1);
    step(2, 0, 1, 0, 8'h5B);
    step(2, 0, 1, 0, 8'h5C);
    step(2, 0, 1, 0, 8'h5D);
    check("fwft_level4", 2, int'(lvl2), 4);
    check("fwft_head", 2, int'(rdata[2]), 8'h5A);
    // Flush with concurrent write and read: both ignored, no errors
    step(2, 1, 1, 1, 8'hEE);
    check("flush_level", 2, int'(lvl2), 0);
    check("flush_errors", 2, int'({werr[2], rerr[2]}), 0);
    check("flush_rdata", 2, int'(rdata[2]), 8'h5A);
    step(2, 0, 1, 0, 8'h3C);
    check("fwft_3c", 2, int'(rdata[2]), 8'h3C);
    step(2, 0, 0, 1, 8'h00);
    check("fwft_pop_level", 2, int'(lvl2), 0);
    check("fwft_pop_rdata", 2, int'(rdata[2]), 8'h3C);
    step(2, 0, 1, 0, 8'h11);
    step(2, 0, 1, 0, 8'h22);
    check("fwft_pre_rst", 2, int'(rdata[2]), 8'h11);

    // Async reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 2, int'(lvl2), 0);
    check("arst_empty", 2, int'(empty[2]), 1);
    check("arst_full", 2, int'(full[2]), 0);
    check("arst_aempty", 2, int'(aempty[2]), 1);
    check("arst_rdata", 2, int'(rdata[2]), 0);
    check("arst_errors", 2, int'({werr[2], rerr[2]}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(2, 0, 0, 0, 8'h00);
    check("arst_after", 2, int'(lvl2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
